wb_trace_fifo: RTL and testbench

// - Trace collector on the output side of the pipelined MIPS core. Captures architectural

---
 rtl/wb_trace_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_wb_trace_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures architectural write events of the pipelined MIPS core
// (GRF writeback from W, DM store from M) into a record FIFO and drains them to a
// consumer over a valid/ready handshake. The core is never stalled; events that do
// not fit are dropped and counted.
//
// Optional feature macro: TRACE_TSTAMP_EN
//   defined   -> every record carries a 32-bit free-running cycle stamp, exposed
//                on trace_tstamp.
//   undefined -> no stamp counter, no trace_tstamp port, 97-bit records.
//
// Record layout (LSB first): data[31:0], addr[63:32], pc[95:64], kind[96],
// and, with the stamp enabled, tstamp[128:97].

module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       grf_we,
  input  logic [4:0]                 grf_addr,
  input  logic [31:0]                grf_wdata,
  input  logic [31:0]                grf_pc,
  input  logic                       dm_we,
  input  logic [31:0]                dm_addr,
  input  logic [31:0]                dm_wdata,
  input  logic [31:0]                dm_pc,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic                       trace_kind,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_addr,
  output logic [31:0]                trace_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt
`ifdef TRACE_TSTAMP_EN
  ,
  output logic [31:0]                trace_tstamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef TRACE_TSTAMP_EN
  localparam int REC_W = 129;
`else
  localparam int REC_W = 97;
`endif

  // Storage and bookkeeping
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  // Event qualification and admission
  logic             w_g;
  logic             w_d;
  logic [LW-1:0]    w_free;
  logic [REC_W-1:0] w_rec_grf;
  logic [REC_W-1:0] w_rec_dm;
  logic             w_push0_en;
  logic             w_push1_en;
  logic [REC_W-1:0] w_push0_rec;
  logic [REC_W-1:0] w_push1_rec;
  logic [1:0]       w_n_push;
  logic [1:0]       w_n_drop;
  logic             w_pop;
  logic [AW-1:0]    w_wr_ptr1;
  logic [CNT_W:0]   w_drop_sum;
  logic [REC_W-1:0] w_head;

`ifdef TRACE_TSTAMP_EN
  logic [31:0]      r_tstamp;

  // Free-running cycle stamp shared by both records of a cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tstamp <= 32'd0;
    end else begin
      r_tstamp <= r_tstamp + 32'd1;
    end
  end

  assign w_rec_grf = {r_tstamp, 1'b0, grf_pc, {27'd0, grf_addr}, grf_wdata};
  assign w_rec_dm  = {r_tstamp, 1'b1, dm_pc, dm_addr, dm_wdata};
`else
  assign w_rec_grf = {1'b0, grf_pc, {27'd0, grf_addr}, grf_wdata};
  assign w_rec_dm  = {1'b1, dm_pc, dm_addr, dm_wdata};
`endif

  // Writes to $0 have no architectural effect, so they are filtered out entirely
  assign w_g = trace_en & grf_we & (grf_addr != 5'd0);
  assign w_d = trace_en & dm_we;

  // Room is judged on the pre-pop occupancy; a same-cycle pop never makes room
  assign w_free    = LW'(DEPTH) - r_level;
  assign w_pop     = (r_level != '0) & trace_ready;
  assign w_wr_ptr1 = r_wr_ptr + AW'(1);

  // Admission: GRF (older W-stage instruction) is always placed ahead of DM
  always_comb begin
    w_push0_en  = 1'b0;
    w_push1_en  = 1'b0;
    w_push0_rec = w_rec_grf;
    w_push1_rec = w_rec_dm;
    w_n_push    = 2'd0;
    w_n_drop    = 2'd0;
    if (w_free >= LW'(2)) begin
      if (w_g && w_d) begin
        w_push0_en = 1'b1;
        w_push1_en = 1'b1;
        w_n_push   = 2'd2;
      end else if (w_g) begin
        w_push0_en = 1'b1;
        w_n_push   = 2'd1;
      end else if (w_d) begin
        w_push0_en  = 1'b1;
        w_push0_rec = w_rec_dm;
        w_n_push    = 2'd1;
      end
    end else if (w_free == LW'(1)) begin
      if (w_g) begin
        w_push0_en = 1'b1;
        w_n_push   = 2'd1;
        w_n_drop   = {1'b0, w_d};
      end else if (w_d) begin
        w_push0_en  = 1'b1;
        w_push0_rec = w_rec_dm;
        w_n_push    = 2'd1;
      end
    end else begin
      w_n_drop = {1'b0, w_g} + {1'b0, w_d};
    end
  end

  // Record storage; admission guarantees only free slots are written
  always_ff @(posedge clk) begin
    if (w_push0_en) begin
      r_mem[r_wr_ptr] <= w_push0_rec;
    end
    if (w_push1_en) begin
      r_mem[w_wr_ptr1] <= w_push1_rec;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_level  <= r_level + LW'(w_n_push) - LW'(w_pop);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_n_drop);

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_n_drop != 2'd0) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  // Head presentation; record fields read as zero whenever nothing is held
  always_comb begin
    trace_valid = (r_level != '0);
    trace_kind  = 1'b0;
    trace_pc    = 32'd0;
    trace_addr  = 32'd0;
    trace_data  = 32'd0;
`ifdef TRACE_TSTAMP_EN
    trace_tstamp = 32'd0;
`endif
    if (trace_valid) begin
      trace_kind = w_head[96];
      trace_pc   = w_head[95:64];
      trace_addr = w_head[63:32];
      trace_data = w_head[31:0];
`ifdef TRACE_TSTAMP_EN
      trace_tstamp = w_head[128:97];
`endif
    end
  end

  assign level    = r_level;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: a queue-based reference model admits
// events at each rising edge, a negedge monitor compares the presented head and
// status against it, and directed phases check the documented corner cases.

module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int LW    = 5;

  logic             clk;
  logic             reset;
  logic             trace_en;
  logic             grf_we;
  logic [4:0]       grf_addr;
  logic [31:0]      grf_wdata;
  logic [31:0]      grf_pc;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_pc;
  logic             trace_valid;
  logic             trace_ready;
  logic             trace_kind;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_addr;
  logic [31:0]      trace_data;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .trace_en   (trace_en),
    .grf_we     (grf_we),
    .grf_addr   (grf_addr),
    .grf_wdata  (grf_wdata),
    .grf_pc     (grf_pc),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_pc      (dm_pc),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_kind (trace_kind),
    .trace_pc   (trace_pc),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .level      (level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    bit          kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  rec_t exp_q[$];
  int   m_level;
  bit   m_ovf;
  int   m_drop;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: events fill free slots in program order, the rest are dropped
  always @(posedge clk) begin
    if (!reset) begin
      int free;
      int pushed;
      int dropped;
      bit pop;
      rec_t r;
      free    = DEPTH - m_level;
      pushed  = 0;
      dropped = 0;
      pop     = (m_level > 0) && trace_ready;
      if (trace_en && grf_we && grf_addr != 5'd0) begin
        if (free > 0) begin
          r.kind = 1'b0; r.pc = grf_pc; r.addr = {27'd0, grf_addr}; r.data = grf_wdata;
          exp_q.push_back(r);
          pushed++;
          free--;
        end else begin
          dropped++;
        end
      end
      if (trace_en && dm_we) begin
        if (free > 0) begin
          r.kind = 1'b1; r.pc = dm_pc; r.addr = dm_addr; r.data = dm_wdata;
          exp_q.push_back(r);
          pushed++;
          free--;
        end else begin
          dropped++;
        end
      end
      m_level = m_level + pushed - (pop ? 1 : 0);
      if (dropped > 0) begin
        m_ovf  = 1'b1;
        m_drop = m_drop + dropped;
        if (m_drop > (1 << CNT_W) - 1) m_drop = (1 << CNT_W) - 1;
      end
    end
  end

  // Monitor: compare status and head record away from the rising edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", trace_valid, (m_level != 0));
      chk("level", level, m_level);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (trace_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 1, 0);
        end else begin
          chk("rec_kind", trace_kind, exp_q[0].kind);
          chk("rec_pc", trace_pc, exp_q[0].pc);
          chk("rec_addr", trace_addr, exp_q[0].addr);
          chk("rec_data", trace_data, exp_q[0].data);
          if (trace_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_fields_zero", (trace_kind || trace_pc != 0 || trace_addr != 0 || trace_data != 0), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    grf_we = 1'b0; grf_addr = 5'd0; grf_wdata = 32'd0; grf_pc = 32'd0;
    dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_pc = 32'd0;
  endtask

  task automatic set_grf(input logic [4:0] a, input logic [31:0] dt, input logic [31:0] pc);
    grf_we = 1'b1; grf_addr = a; grf_wdata = dt; grf_pc = pc;
  endtask

  task automatic set_dm(input logic [31:0] a, input logic [31:0] dt, input logic [31:0] pc);
    dm_we = 1'b1; dm_addr = a; dm_wdata = dt; dm_pc = pc;
  endtask

  task automatic drain(input int n);
    clr_ev();
    trace_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    total = 0; bad = 0; m_level = 0; m_ovf = 0; m_drop = 0;
    reset = 1'b1; trace_en = 1'b0; trace_ready = 1'b0;
    clr_ev();
    repeat (2) tick();
    chk("rst_valid", trace_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_fields", {trace_kind, trace_pc | trace_addr | trace_data}, 0);
    reset = 1'b0;
    trace_en = 1'b1;
    tick();

    // Single GRF write, one cycle latency
    set_grf(5'd8, 32'h1234, 32'h3000);
    tick();
    clr_ev();
    chk("single_valid", trace_valid, 1);
    chk("single_kind", trace_kind, 0);
    chk("single_addr", trace_addr, 8);
    chk("single_data", trace_data, 32'h1234);
    chk("single_pc", trace_pc, 32'h3000);
    chk("single_level", level, 1);
    drain(2);

    // Writes to $0 are neither recorded nor dropped
    trace_ready = 1'b0;
    set_grf(5'd0, 32'hdead, 32'h3100);
    repeat (3) tick();
    clr_ev();
    tick();
    chk("zero_valid", trace_valid, 0);
    chk("zero_drop", drop_cnt, 0);
    chk("zero_ovf", overflow, 0);

    // Dual event, GRF first
    trace_ready = 1'b1;
    set_grf(5'd5, 32'h55, 32'h3004);
    set_dm(32'h10, 32'hAB, 32'h3008);
    tick();
    clr_ev();
    chk("dual_level0", level, 2);
    chk("dual_first_kind", trace_kind, 0);
    chk("dual_first_pc", trace_pc, 32'h3004);
    tick();
    chk("dual_level1", level, 1);
    chk("dual_second_kind", trace_kind, 1);
    chk("dual_second_pc", trace_pc, 32'h3008);
    chk("dual_second_addr", trace_addr, 32'h10);
    chk("dual_second_data", trace_data, 32'hAB);
    tick();
    chk("dual_level2", level, 0);

    // Overflow: fill to 15, then dual events at free==1 and free==0
    trace_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      set_grf(5'($urandom_range(1, 31)), $urandom, 32'h4000 + 4 * i);
      tick();
    end
    chk("ovf_pre_level", level, 15);
    set_grf(5'd3, 32'hC0FFEE, 32'h5000);
    set_dm(32'h20, 32'hBEEF, 32'h5004);
    tick();
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop1", drop_cnt, 1);
    tick();
    clr_ev();
    chk("ovf_drop3", drop_cnt, 3);
    chk("ovf_level_full", level, 16);
    drain(20);
    chk("ovf_drained", level, 0);

    // Wrap with concurrent pop
    trace_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_grf(5'($urandom_range(1, 31)), $urandom, 32'h6000 + 4 * i);
      tick();
      chk("wrap_level", level, 1);
    end
    drain(3);
    chk("wrap_drained", level, 0);

    // Randomized traffic with varying consumer pressure
    for (int i = 0; i < 500; i++) begin
      trace_en    = ($urandom_range(0, 7) != 0);
      grf_we      = $urandom_range(0, 1);
      grf_addr    = 5'($urandom_range(0, 31));
      grf_wdata   = $urandom;
      grf_pc      = $urandom;
      dm_we       = $urandom_range(0, 1);
      dm_addr     = $urandom;
      dm_wdata    = $urandom;
      dm_pc       = $urandom;
      trace_ready = (i < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    trace_en = 1'b1;
    drain(40);
    chk("rand_drained", level, 0);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Drop counter saturation
    trace_ready = 1'b0;
    set_grf(5'd9, 32'h99, 32'h7000);
    set_dm(32'h40, 32'h77, 32'h7004);
    repeat (150) tick();
    clr_ev();
    chk("sat_drop", drop_cnt, 8'hFF);
    chk("sat_ovf", overflow, 1);
    drain(20);

    // Asynchronous reset in the middle of a drain
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_grf(5'(i + 1), 32'h100 + i, 32'h8000 + 4 * i);
      tick();
    end
    clr_ev();
    chk("arst_pre_level", level, 5);
    trace_ready = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("arst_valid", trace_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_drop", drop_cnt, 0);
    exp_q.delete();
    m_level = 0; m_ovf = 0; m_drop = 0;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arst_no_emit", trace_valid, 0);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
